// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared types and constants for the multi-cycle sequencing
// controller.
//   state_e    - FSM state encoding; this is also the value driven on the
//                controller's `state` port.
//   OP_*       - 7-bit major opcodes that the controller recognises.
//   op_class_e - class of the decoded instruction, latched in DECODE.
//   classify() - maps an opcode to its class.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;  // ebreak

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_EBREAK,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] op);
    case (op)
      OP_R_ALU, OP_I_ALU: return CLS_ALU;
      OP_LOAD:            return CLS_LOAD;
      OP_STORE:           return CLS_STORE;
      OP_BRANCH:          return CLS_BRANCH;
      OP_SYSTEM:          return CLS_EBREAK;
      default:            return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/seq_controller_wait_timer.sv
// wait_timer: counts the cycles a memory request has been waiting for ready.
//   clk           - rising-edge clock
//   reset         - synchronous, active-high reset; clears the count
//   clear         - zero the count (takes priority over count_en)
//   count_en      - advance the count by one this cycle
//   limit_reached - count equals LIMIT
// The count saturates at LIMIT, so it can never wrap back to zero and hide a
// timeout.
module wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic limit_reached
);

  localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  // NOTE: assign every always_comb output a default first, so that no path
  // through the block leaves a value unassigned and infers a latch.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != LIMIT_W)) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: flops are assigned with <= so every register samples the values it
  // had before the clock edge, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limit_reached = (count_q == LIMIT_W);

endmodule

// File: rtl/seq_controller.sv
// seq_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
//   clk, reset                      - clock; synchronous, active-high reset
//   opcode                          - instruction opcode, valid from DECODE on
//   branch_taken                    - branch decision, consumed in EXEC
//   imem_ready / dmem_ready         - memory handshakes (FETCH / MEM only)
//   imem_req, ir_we, pc_we, pc_sel,
//   reg_we, dmem_req, dmem_we       - datapath sequencing strobes
//   state                           - current FSM state (seq_ctrl_pkg::state_e)
//   halted, illegal, bus_error      - sticky status flags, cleared by reset
//   instret                         - retired-instruction counter (wraps)
module seq_controller
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic        bus_error,
  output logic [63:0] instret
);

  state_e      state_q, state_d;
  op_class_e   cls_q, cls_d;
  logic [63:0] instret_q, instret_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  logic        bus_error_q, bus_error_d;
  logic        retire;
  logic        timer_clear, timer_en, timer_limit;

  wait_timer #(.LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk           (clk),
    .reset         (reset),
    .clear         (timer_clear),
    .count_en      (timer_en),
    .limit_reached (timer_limit)
  );

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    retire      = 1'b0;
    timer_en    = 1'b0;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    reg_we      = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else begin
          // Ready arriving in the cycle the limit is reached takes the branch
          // above, so it still wins over the timeout.
          timer_en = 1'b1;
          if (timer_limit) begin
            state_d     = ST_HALT;
            bus_error_d = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        cls_d = classify(opcode);
        case (cls_d)
          CLS_EBREAK:  state_d = ST_HALT;
          CLS_ILLEGAL: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
          default:     state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        if (dmem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          timer_en = 1'b1;
          if (timer_limit) begin
            state_d     = ST_HALT;
            bus_error_d = 1'b1;
          end
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: ;
      // Unused encodings 6-7 park in HALT.
      default: state_d = ST_HALT;
    endcase

    // Reset abandons the instruction in flight: no strobe may reach the
    // datapath in the cycle it is asserted.
    if (reset) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      reg_we   = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end

    instret_d   = retire ? instret_q + 64'd1 : instret_q;
    halted_d    = halted_q | (state_d == ST_HALT);
    // Each new memory request starts its wait count from zero.
    timer_clear = (state_d != state_q) &&
                  ((state_d == ST_FETCH) || (state_d == ST_MEM));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      cls_q       <= CLS_ALU;
      instret_q   <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      instret_q   <= instret_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign state     = state_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: randomized self-checking bench for seq_controller.
// Each instruction is described by its opcode and memory wait lengths; the
// bench expands that into the cycle-by-cycle trace the controller must
// produce (states, strobes, flags) and compares it against the DUT.
module tb_seq_controller;

  localparam int unsigned LIMIT = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_EBK = 7'b1110011;

  // Strobe vector order: {imem_req, ir_we, pc_we, reg_we, dmem_req, dmem_we}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IREQ = 6'b100000;
  localparam logic [5:0] S_IRWE = 6'b010000;
  localparam logic [5:0] S_PC   = 6'b001000;
  localparam logic [5:0] S_REG  = 6'b000100;
  localparam logic [5:0] S_DREQ = 6'b000010;
  localparam logic [5:0] S_DWE  = 6'b000001;

  // Flag vector order: {halted, illegal, bus_error}
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_EBK  = 3'b100;
  localparam logic [2:0] F_ILL  = 3'b110;
  localparam logic [2:0] F_BUS  = 3'b101;

  typedef struct {
    logic [2:0] st;
    logic [5:0] strb;
    logic       sel;
    logic [2:0] fl;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        branch_taken, imem_ready, dmem_ready;
  logic        imem_req, ir_we, pc_we, pc_sel, reg_we, dmem_req, dmem_we;
  logic [2:0]  state;
  logic        halted, illegal, bus_error;
  logic [63:0] instret;

  logic [63:0] model_instret;
  int          n_checks;
  int          n_pass;

  always #5 clk = ~clk;

  seq_controller #(.WAIT_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .state        (state),
    .halted       (halted),
    .illegal      (illegal),
    .bus_error    (bus_error),
    .instret      (instret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cyc_t mk(input logic [2:0] st, input logic [5:0] strb,
                              input logic sel, input logic [2:0] fl);
    cyc_t c;
    c.st   = st;
    c.strb = strb;
    c.sel  = sel;
    c.fl   = fl;
    return c;
  endfunction

  // Called just after a rising edge; holds reset for one edge, then releases.
  task automatic do_reset();
    reset        = 1'b1;
    opcode       = 7'($urandom);
    imem_ready   = 1'($urandom);
    dmem_ready   = 1'($urandom);
    branch_taken = 1'($urandom);
    @(negedge clk);
    check("strobes_in_reset",
          64'({imem_req, ir_we, pc_we, reg_we, dmem_req, dmem_we}), 64'(S_NONE));
    @(posedge clk);
    #1;
    reset         = 1'b0;
    model_instret = '0;
  endtask

  // Runs one instruction from its first FETCH cycle. wi/wd are the number of
  // cycles imem_ready/dmem_ready stay low before rising. abort_at >= 0 asserts
  // reset in that cycle instead. do_force preloads instret to all-ones.
  task automatic run_instr(input logic [6:0] op, input int wi, input int wd,
                           input logic bt, input int abort_at, input bit do_force);
    cyc_t       q[$];
    int         fetch_len, mem_len, exec_at, mem_start, n;
    bit         fetch_ok, mem_ok, is_mem, is_store, retires, halts, abort;
    logic [2:0] halt_fl;
    logic [5:0] got_strb;

    mem_len  = 0;
    is_mem   = 1'b0;
    is_store = 1'b0;
    retires  = 1'b0;
    halts    = 1'b0;
    halt_fl  = F_NONE;
    fetch_ok  = (wi <= int'(LIMIT));
    fetch_len = fetch_ok ? wi + 1 : int'(LIMIT) + 1;
    exec_at   = fetch_len + 1;
    mem_start = fetch_len + 2;

    for (int k = 0; k < fetch_len; k++) begin
      q.push_back(mk(3'd0, (fetch_ok && k == fetch_len - 1) ? (S_IREQ | S_IRWE) : S_IREQ,
                     1'b0, F_NONE));
    end
    if (!fetch_ok) begin
      halts   = 1'b1;
      halt_fl = F_BUS;
    end else begin
      q.push_back(mk(3'd1, S_NONE, 1'b0, F_NONE));
      case (op)
        OP_R, OP_I: begin
          q.push_back(mk(3'd2, S_NONE, 1'b0, F_NONE));
          q.push_back(mk(3'd4, S_REG | S_PC, 1'b0, F_NONE));
          retires = 1'b1;
        end
        OP_BR: begin
          q.push_back(mk(3'd2, S_PC, bt, F_NONE));
          retires = 1'b1;
        end
        OP_LD, OP_ST: begin
          is_mem   = 1'b1;
          is_store = (op == OP_ST);
          mem_ok   = (wd <= int'(LIMIT));
          mem_len  = mem_ok ? wd + 1 : int'(LIMIT) + 1;
          q.push_back(mk(3'd2, S_NONE, 1'b0, F_NONE));
          for (int j = 0; j < mem_len; j++) begin
            q.push_back(mk(3'd3,
                           S_DREQ | (is_store ? S_DWE : S_NONE) |
                           ((is_store && mem_ok && j == mem_len - 1) ? S_PC : S_NONE),
                           1'b0, F_NONE));
          end
          if (!mem_ok) begin
            halts   = 1'b1;
            halt_fl = F_BUS;
          end else if (!is_store) begin
            q.push_back(mk(3'd4, S_REG | S_PC, 1'b0, F_NONE));
            retires = 1'b1;
          end else begin
            retires = 1'b1;
          end
        end
        OP_EBK: begin
          halts   = 1'b1;
          halt_fl = F_EBK;
        end
        default: begin
          halts   = 1'b1;
          halt_fl = F_ILL;
        end
      endcase
    end
    if (halts) begin
      repeat (10) q.push_back(mk(3'd5, S_NONE, 1'b0, halt_fl));
    end

    n = q.size();
    for (int k = 0; k < n; k++) begin
      abort        = (k == abort_at);
      reset        = abort;
      opcode       = (k < fetch_len) ? 7'($urandom) : op;
      imem_ready   = (k < fetch_len) ? (k >= wi) : 1'($urandom);
      dmem_ready   = (is_mem && k >= mem_start && k < mem_start + mem_len) ?
                     (k - mem_start >= wd) : 1'($urandom);
      branch_taken = (k == exec_at) ? bt : 1'($urandom);
      if (do_force && k == 0) begin
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        model_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      if (do_force && k == 2) release dut.instret_q;
      @(negedge clk);
      got_strb = {imem_req, ir_we, pc_we, reg_we, dmem_req, dmem_we};
      check("state", 64'(state), 64'(q[k].st));
      if (abort) begin
        check("strobes_abort", 64'(got_strb), 64'(S_NONE));
      end else begin
        check("strobes", 64'(got_strb), 64'(q[k].strb));
        if (q[k].strb[3]) check("pc_sel", 64'(pc_sel), 64'(q[k].sel));
      end
      check("flags", 64'({halted, illegal, bus_error}), 64'(q[k].fl));
      check("instret", instret, model_instret);
      @(posedge clk);
      #1;
      if (abort) begin
        reset         = 1'b0;
        model_instret = '0;
        return;
      end
    end
    if (retires) model_instret = model_instret + 64'd1;
  endtask

  logic [6:0] legal_ops [5];

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    model_instret = '0;
    legal_ops     = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};
    reset         = 1'b1;
    opcode        = '0;
    branch_taken  = 1'b0;
    imem_ready    = 1'b0;
    dmem_ready    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 64'(state), 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_flags", 64'({halted, illegal, bus_error}), 64'd0);
    check("reset_strobes", 64'({imem_req, ir_we, pc_we, reg_we, dmem_req, dmem_we}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed: R-type, load with 3 wait cycles, taken and not-taken branches
    run_instr(OP_R,  0, 0, 1'b0, -1, 1'b0);
    run_instr(OP_LD, 0, 3, 1'b0, -1, 1'b0);
    run_instr(OP_BR, 0, 0, 1'b1, -1, 1'b0);
    run_instr(OP_BR, 1, 0, 1'b0, -1, 1'b0);

    // instret wrap on a retiring store
    run_instr(OP_ST, 2, 0, 1'b0, -1, 1'b1);

    // Randomized legal instruction stream
    for (int i = 0; i < 60; i++) begin
      int wi, wd;
      wi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LIMIT)) : 0;
      wd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LIMIT)) : 0;
      run_instr(legal_ops[$urandom_range(0, 4)], wi, wd, 1'($urandom), -1, 1'b0);
    end

    // Ready rising exactly when the wait count reaches the limit
    run_instr(OP_I,  int'(LIMIT), 0, 1'b0, -1, 1'b0);
    run_instr(OP_ST, 0, int'(LIMIT), 1'b0, -1, 1'b0);
    run_instr(OP_LD, int'(LIMIT), int'(LIMIT), 1'b0, -1, 1'b0);

    // Reset in WB of an R-type and in the completing MEM cycle of a store
    run_instr(OP_R,  0, 0, 1'b0, 3, 1'b0);
    run_instr(OP_ST, 0, 0, 1'b0, 3, 1'b0);
    run_instr(OP_BR, 0, 0, 1'b1, 2, 1'b0);

    // Bus errors on instruction and data memory
    run_instr(OP_R,  int'(LIMIT) + 1, 0, 1'b0, -1, 1'b0);
    do_reset();
    run_instr(OP_LD, 0, int'(LIMIT) + 1, 1'b0, -1, 1'b0);
    do_reset();
    run_instr(OP_ST, 2, 2, 1'b0, -1, 1'b0);

    // Illegal opcode and ebreak
    run_instr(7'b1111111, 0, 0, 1'b0, -1, 1'b0);
    do_reset();
    run_instr(OP_EBK, 1, 0, 1'b0, -1, 1'b0);
    do_reset();

    // Random opcodes, mostly illegal; the model classifies each one
    for (int i = 0; i < 6; i++) begin
      run_instr(7'($urandom), $urandom_range(0, 2), 0, 1'($urandom), -1, 1'b0);
      do_reset();
    end

    run_instr(OP_I, 3, 0, 1'b0, -1, 1'b0);
    run_instr(OP_LD, 1, 2, 1'b0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
